// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: opcodes, ALU codes,
// instruction field positions, control-FSM states and PC source encodings.
package cpu_pkg;

   localparam int INSTR_W = 16;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 13;
   localparam int FUNC_MSB = 3;
   localparam int FUNC_LSB = 0;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_ADDI  = 3'b001;
   localparam logic [2:0] OP_LW    = 3'b010;
   localparam logic [2:0] OP_SW    = 3'b011;
   localparam logic [2:0] OP_BEQ   = 3'b100;
   localparam logic [2:0] OP_J     = 3'b101;
   localparam logic [2:0] OP_ILL   = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_NOT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   localparam logic [1:0] PC_SRC_INC    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] instr_func(input logic [INSTR_W-1:0] instr);
      return instr[FUNC_MSB:FUNC_LSB];
   endfunction

endpackage

// File: rtl/cpu_mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath:
// IR/flag inputs, the shared memory handshake and all datapath strobes.
interface cpu_mc_ctrl_if;
   import cpu_pkg::*;

   logic [INSTR_W-1:0] instr;
   logic               zero;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_we;
   logic               mem_addr_sel;
   logic               ir_we;
   logic               pc_we;
   logic [1:0]         pc_src;
   logic               alu_src_b;
   logic [2:0]         alu_code;
   logic               rf_we;
   logic               rf_dst_sel;
   logic               rf_wdata_sel;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
             alu_src_b, alu_code, rf_we, rf_dst_sel, rf_wdata_sel
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
             alu_src_b, alu_code, rf_we, rf_dst_sel, rf_wdata_sel
   );

endinterface

// File: rtl/alu_func_decode.sv
// R-type func field to ALU operation; flags func codes with no ALU operation.
module alu_func_decode
   import cpu_pkg::*;
(
   input  logic [3:0] func_i,
   output logic [2:0] alu_code_o,
   output logic       func_illegal_o
);

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      alu_code_o     = ALU_ADD;
      func_illegal_o = 1'b0;
      case (func_i)
         4'b0000: alu_code_o = ALU_ADD;
         4'b0001: alu_code_o = ALU_SUB;
         4'b0100: alu_code_o = ALU_AND;
         4'b0101: alu_code_o = ALU_OR;
         4'b0110: alu_code_o = ALU_NOT;
         4'b0111: alu_code_o = ALU_XOR;
         default: func_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// owns the shared memory port with a bounded req/ready wait.
module cpu_mc_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   cpu_mc_ctrl_if.master    ctl,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   logic [2:0]         opcode;
   logic [3:0]         func;
   logic [2:0]         rtype_code;
   logic               func_illegal;
   logic [2:0]         exec_code;
   logic               exec_src_b;
   logic               waiting;
   logic               timeout;
   logic               retire;
   logic               unused_instr_fields;

   assign opcode              = instr_opcode(ctl.instr);
   assign func                = instr_func(ctl.instr);
   assign unused_instr_fields = ^ctl.instr[OPC_LSB-1:FUNC_MSB+1];

   alu_func_decode u_func_dec (
      .func_i         (func),
      .alu_code_o     (rtype_code),
      .func_illegal_o (func_illegal)
   );

   // ALU setup is shared by EXEC and MEM so the memory address stays stable.
   always_comb begin
      exec_code  = ALU_ADD;
      exec_src_b = 1'b0;
      case (opcode)
         OP_RTYPE:              exec_code  = rtype_code;
         OP_ADDI, OP_LW, OP_SW: exec_src_b = 1'b1;
         OP_BEQ:                exec_code  = ALU_SUB;
         default:               ;
      endcase
   end

   assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !ctl.mem_ready;
   assign timeout = waiting && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tmo_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         retired_q <= retired_d;
      end
   end

   assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

   always_comb begin
      state_d   = state_q;
      tmo_d     = '0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH, S_MEM: begin
            if (ctl.mem_ready) begin
               if (state_q == S_FETCH)  state_d = S_DECODE;
               else if (opcode == OP_LW) state_d = S_WB;
               else                      state_d = S_FETCH;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_J:    state_d = S_FETCH;
               OP_HALT: state_d = S_HALT;
               OP_ILL: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
               OP_RTYPE: begin
                  illegal_d = illegal_q | func_illegal;
                  state_d   = func_illegal ? S_HALT : S_EXEC;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_BEQ:       state_d = S_FETCH;
               OP_LW, OP_SW: state_d = S_MEM;
               default:      state_d = S_WB;
            endcase
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ctl.mem_req      = 1'b0;
      ctl.mem_we       = 1'b0;
      ctl.mem_addr_sel = 1'b0;
      ctl.ir_we        = 1'b0;
      ctl.pc_we        = 1'b0;
      ctl.pc_src       = PC_SRC_INC;
      ctl.alu_src_b    = 1'b0;
      ctl.alu_code     = ALU_ADD;
      ctl.rf_we        = 1'b0;
      ctl.rf_dst_sel   = 1'b0;
      ctl.rf_wdata_sel = 1'b0;
      retire           = 1'b0;
      case (state_q)
         S_FETCH: begin
            ctl.mem_req = 1'b1;
            if (ctl.mem_ready) begin
               ctl.ir_we  = 1'b1;
               ctl.pc_we  = 1'b1;
               ctl.pc_src = PC_SRC_INC;
            end
         end
         S_DECODE: begin
            if (opcode == OP_J) begin
               ctl.pc_we  = 1'b1;
               ctl.pc_src = PC_SRC_JUMP;
               retire     = 1'b1;
            end
         end
         S_EXEC: begin
            ctl.alu_code  = exec_code;
            ctl.alu_src_b = exec_src_b;
            if (opcode == OP_BEQ) begin
               retire = 1'b1;
               if (ctl.zero) begin
                  ctl.pc_we  = 1'b1;
                  ctl.pc_src = PC_SRC_BRANCH;
               end
            end
         end
         S_MEM: begin
            ctl.mem_req      = 1'b1;
            ctl.mem_addr_sel = 1'b1;
            ctl.mem_we       = (opcode == OP_SW);
            ctl.alu_code     = exec_code;
            ctl.alu_src_b    = exec_src_b;
            retire           = ctl.mem_ready && (opcode == OP_SW);
         end
         S_WB: begin
            ctl.rf_we        = 1'b1;
            ctl.rf_dst_sel   = (opcode != OP_RTYPE);
            ctl.rf_wdata_sel = (opcode == OP_LW);
            retire           = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Self-checking bench for cpu_mc_ctrl: an instruction-level timeline model
// predicts every cycle's strobes and is compared against the DUT on negedges.
module tb_cpu_mc_ctrl;

   localparam int TMO      = 8;
   localparam int TB_CNT_W = 5;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_b;
      logic [2:0] alu_code;
      logic       rf_we;
      logic       rf_dst_sel;
      logic       rf_wdata_sel;
      logic       halted;
      logic       illegal;
      logic       bus_err;
   } outs_t;

   logic                clk;
   logic                rst_n;
   logic                halted, illegal, bus_err;
   logic [TB_CNT_W-1:0] retired;

   cpu_mc_ctrl_if ctl ();

   cpu_mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(TB_CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctl     (ctl.master),
      .halted  (halted),
      .illegal (illegal),
      .bus_err (bus_err),
      .retired (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                  n_total = 0;
   int                  n_bad   = 0;
   int                  ncyc    = 0;
   bit                  chk_en  = 0;
   outs_t               exp_o;
   outs_t               got_o;
   logic [TB_CNT_W-1:0] exp_ret;
   logic [TB_CNT_W-1:0] m_ret;
   bit                  m_halted, m_illegal, m_bus_err;

   assign got_o = {ctl.mem_req, ctl.mem_we, ctl.mem_addr_sel, ctl.ir_we, ctl.pc_we,
                   ctl.pc_src, ctl.alu_src_b, ctl.alu_code, ctl.rf_we, ctl.rf_dst_sel,
                   ctl.rf_wdata_sel, halted, illegal, bus_err};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("outs", 32'(got_o), 32'(exp_o));
         check("retired", 32'(retired), 32'(exp_ret));
      end
   end

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit func_legal(input logic [3:0] f);
      return f inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
   endfunction

   // Legal R-type funcs name their ALU op in the low three bits.
   function automatic logic [2:0] spec_alu(input logic [2:0] op, input logic [3:0] f);
      if (op == 3'b100) return 3'b001;
      if (op != 3'b000) return 3'b000;
      return f[2:0];
   endfunction

   // One clock of the timeline: drive inputs, publish expectations, advance.
   task automatic cyc(input logic rdy, input logic z, input outs_t e, input bit ret);
      ctl.mem_ready = rdy;
      ctl.zero      = z;
      exp_o         = e;
      exp_o.halted  = m_halted;
      exp_o.illegal = m_illegal;
      exp_o.bus_err = m_bus_err;
      exp_ret       = m_ret;
      chk_en        = 1'b1;
      @(posedge clk);
      #1;
      if (ret) m_ret = m_ret + 1'b1;
      ncyc++;
   endtask

   task automatic wait_phase(input int w, input outs_t e, input bit scramble, output bit ok);
      ok = 1'b1;
      for (int k = 0; k < w; k++) begin
         if (scramble) ctl.instr = 16'($urandom);
         cyc(1'b0, rbit(), e, 1'b0);
         if (k == TMO - 1) begin
            m_halted  = 1'b1;
            m_bus_err = 1'b1;
            ok        = 1'b0;
            return;
         end
      end
   endtask

   task automatic halt_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         ctl.instr = 16'($urandom);
         cyc(rbit(), rbit(), '0, 1'b0);
      end
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #2;
      check("rst_outs", 32'(got_o), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      m_bus_err = 1'b0;
      m_ret     = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(rbit(), rbit(), '0, 1'b0);
   endtask

   task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                            input logic z, input bit rst_mid, output int n);
      outs_t      e;
      logic [2:0] op;
      logic [3:0] f;
      bit         ok;
      int         c0;
      op = ins[15:13];
      f  = ins[3:0];
      c0 = ncyc;
      n  = 0;
      e  = '0;
      e.mem_req = 1'b1;
      wait_phase(fw, e, 1'b1, ok);
      if (!ok) begin
         n = ncyc - c0;
         return;
      end
      e.ir_we   = 1'b1;
      e.pc_we   = 1'b1;
      ctl.instr = 16'($urandom);
      cyc(1'b1, rbit(), e, 1'b0);
      ctl.instr = ins;
      e = '0;
      if (op == 3'b101) begin
         e.pc_we  = 1'b1;
         e.pc_src = 2'b10;
         cyc(rbit(), rbit(), e, 1'b1);
         n = ncyc - c0;
         return;
      end
      cyc(rbit(), rbit(), e, 1'b0);
      if (op == 3'b111 || op == 3'b110 || (op == 3'b000 && !func_legal(f))) begin
         m_halted = 1'b1;
         if (op != 3'b111) m_illegal = 1'b1;
         n = ncyc - c0;
         return;
      end
      e.alu_code  = spec_alu(op, f);
      e.alu_src_b = op inside {3'b001, 3'b010, 3'b011};
      if (op == 3'b100) begin
         e.pc_we  = z;
         e.pc_src = z ? 2'b01 : 2'b00;
         cyc(rbit(), z, e, 1'b1);
         n = ncyc - c0;
         return;
      end
      cyc(rbit(), rbit(), e, 1'b0);
      if (op == 3'b010 || op == 3'b011) begin
         e.mem_req      = 1'b1;
         e.mem_addr_sel = 1'b1;
         e.mem_we       = (op == 3'b011);
         if (rst_mid) begin
            wait_phase(2, e, 1'b0, ok);
            do_reset();
            n = ncyc - c0;
            return;
         end
         wait_phase(mw, e, 1'b0, ok);
         if (!ok) begin
            n = ncyc - c0;
            return;
         end
         cyc(1'b1, rbit(), e, op == 3'b011);
         if (op == 3'b011) begin
            n = ncyc - c0;
            return;
         end
      end
      e = '0;
      e.rf_we        = 1'b1;
      e.rf_dst_sel   = (op != 3'b000);
      e.rf_wdata_sel = (op == 3'b010);
      cyc(rbit(), rbit(), e, 1'b1);
      n = ncyc - c0;
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] ins;
      int          r;
      int          k;
      ins = 16'($urandom);
      r   = $urandom_range(0, 99);
      if (r < 3)      ins[15:13] = 3'b111;
      else if (r < 6) ins[15:13] = 3'b110;
      else begin
         ins[15:13] = 3'($urandom_range(0, 5));
         if (ins[15:13] == 3'b000 && $urandom_range(0, 9) != 0) begin
            k = $urandom_range(0, 5);
            ins[3:0] = 4'(k < 2 ? k : k + 2);
         end
      end
      return ins;
   endfunction

   function automatic int rand_wait();
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)  return $urandom_range(8, 10);
      if (r < 12) return $urandom_range(4, 7);
      return $urandom_range(0, 2);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] ins;
      rst_n         = 1'b0;
      ctl.instr     = '0;
      ctl.zero      = 1'b0;
      ctl.mem_ready = 1'b0;
      m_ret         = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      run_instr(16'h0001, 0, 0, 1'b0, 1'b0, n);
      check("rsub_lat", 32'(n), 32'd4);
      check("rsub_retired", 32'(retired), 32'd1);
      run_instr(16'h4485, 3, 3, 1'b0, 1'b0, n);
      check("lw_lat", 32'(n), 32'd11);
      check("lw_retired", 32'(retired), 32'd2);
      run_instr(16'h8003, 0, 0, 1'b1, 1'b0, n);
      check("beq_z1_lat", 32'(n), 32'd3);
      run_instr(16'h8003, 0, 0, 1'b0, 1'b0, n);
      check("beq_z0_lat", 32'(n), 32'd3);
      check("beq_retired", 32'(retired), 32'd4);
      run_instr(16'hA123, 0, 0, 1'b0, 1'b0, n);
      check("j_lat", 32'(n), 32'd2);
      run_instr(16'h6411, 0, 0, 1'b0, 1'b0, n);
      check("sw_lat", 32'(n), 32'd4);
      run_instr(16'h2405, 0, 0, 1'b0, 1'b0, n);
      check("addi_lat", 32'(n), 32'd4);
      run_instr(16'h0120, TMO - 1, 0, 1'b0, 1'b0, n);
      check("ready_on_last_lat", 32'(n), 32'd11);
      check("seq_retired", 32'(retired), 32'd8);

      run_instr(16'h0002, 0, 0, 1'b0, 1'b0, n);
      check("illegal_lat", 32'(n), 32'd2);
      check("illegal_flag", 32'(illegal), 32'd1);
      check("illegal_halted", 32'(halted), 32'd1);
      check("illegal_retired", 32'(retired), 32'd8);
      cyc(1'b1, 1'b0, '0, 1'b0);
      halt_cycles(3);
      do_reset();

      run_instr(16'h0001, 20, 0, 1'b0, 1'b0, n);
      check("fetch_tmo_lat", 32'(n), 32'd8);
      check("fetch_tmo_bus_err", 32'(bus_err), 32'd1);
      halt_cycles(3);
      do_reset();

      run_instr(16'h4485, 0, 20, 1'b0, 1'b0, n);
      check("mem_tmo_lat", 32'(n), 32'd11);
      check("mem_tmo_bus_err", 32'(bus_err), 32'd1);
      halt_cycles(2);
      do_reset();

      run_instr(16'h0001, 0, 0, 1'b0, 1'b0, n);
      run_instr(16'h6411, 1, 5, 1'b0, 1'b1, n);
      check("midrst_retired", 32'(retired), 32'd0);
      check("midrst_flags", 32'({illegal, bus_err, halted}), 32'd0);
      run_instr(16'hA000, 0, 0, 1'b0, 1'b0, n);

      for (int i = 0; i < 300; i++) begin
         ins = rand_instr();
         run_instr(ins, rand_wait(), rand_wait(), rbit(),
                   (ins[15:14] == 2'b01) && ($urandom_range(0, 49) == 0), n);
         if (m_halted) begin
            halt_cycles($urandom_range(1, 3));
            do_reset();
         end
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_mc_ctrl.md
Name: cpu_mc_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit CPU.
- Sequences fetch/decode/execute/memory/writeback, drives every datapath strobe, and selects the 3-bit ALU operation.
- Owns the single shared memory port through a req/ready handshake with a timeout.
- Sits between the instruction register/flags of the datapath and the PC, register file, ALU and memory interface.

Parameters:
- MEM_TIMEOUT, 8, max cycles mem_req may stay high without mem_ready before bus error.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  16  IR contents: opcode[15:13], rs[12:10], rt[9:7], rd[6:4], func[3:0]; I-type imm[6:0].
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory completion, sampled only while mem_req=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write, 0=read.
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- ir_we  out  1  load IR from memory data.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  00=PC+1, 01=PC+1+sext(imm), 10=jump target instr[12:0].
- alu_src_b  out  1  0=rt register, 1=sext(imm[6:0]).
- alu_code  out  3  000 add, 001 sub, 100 and, 101 or, 110 not, 111 xor.
- rf_we  out  1  register-file write.
- rf_dst_sel  out  1  0=rd, 1=rt.
- rf_wdata_sel  out  1  0=ALU result, 1=memory data.
- halted  out  1  FSM in HALT.
- illegal  out  1  sticky: halted on an illegal opcode/func.
- bus_err  out  1  sticky: halted on a memory timeout.
- retired  out  CNT_W  count of completed instructions, wraps at 2^CNT_W.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- State, sticky flags, timeout counter and retired are registered. Strobes are decoded combinationally from state, instr, mem_ready and zero.
- Reset: async assert forces IDLE, retired=0, illegal=bus_err=0, timeout counter=0. All outputs are 0 while in IDLE, including alu_code=000. Mid-instruction reset abandons the instruction with no write.
- IDLE -> FETCH unconditionally on the first clock after rst_n deasserts.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - Cycle mem_ready=1: ir_we=1, pc_we=1, pc_src=00, -> DECODE. Otherwise stay.
- Opcode map: 000 R-type, 001 addi, 010 lw, 011 sw, 100 beq, 101 j, 110 illegal, 111 halt.
- DECODE:
  - j: pc_we=1, pc_src=10, retire, -> FETCH.
  - halt: -> HALT.
  - 110, or R-type with func not in {0000,0001,0100,0101,0110,0111}: set illegal, -> HALT.
  - Else -> EXEC.
- EXEC alu_code:
  - R-type: func 0000->000, 0001->001, 0100->100, 0101->101, 0110->110, 0111->111.
  - addi/lw/sw: 000 with alu_src_b=1.
  - beq: 001 with alu_src_b=0.
- EXEC next state:
  - beq: if zero then pc_we=1, pc_src=01; retire; -> FETCH.
  - R/addi -> WB.
  - lw/sw -> MEM.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_code holds the EXEC value, mem_we=1 for sw.
  - On mem_ready: sw retires -> FETCH; lw -> WB.
- WB: rf_we=1 for exactly one cycle, retire, -> FETCH.
  - R: rf_dst_sel=0, rf_wdata_sel=0.
  - addi: rf_dst_sel=1, rf_wdata_sel=0.
  - lw: rf_dst_sel=1, rf_wdata_sel=1.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable until the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
  - Timeout counter clears on entry to FETCH/MEM and increments each waiting cycle. When it reaches MEM_TIMEOUT without mem_ready: set bus_err, -> HALT, no strobes that cycle.
  - mem_ready arriving on the timeout cycle wins; no error.
- HALT: all strobes 0, halted=1; exit only via reset.
- Minimum latencies in cycles (FETCH ready on its first cycle): j 2, beq 3, R/addi 4, sw 4, lw 5.
- Retire increments retired by 1 in the same cycle as the final strobe. Halt and illegal do not retire.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants and ALU code constants;
  - instruction field bit positions;
  - the state enum;
  - pc_src encodings.
- One sub-module: alu_func_decode, combinational func -> {alu_code, func_illegal}, instantiated once in EXEC decode.

Test Plan:
- R-type sub (instr=16'h0001 pattern, func=0001), mem_ready immediate:
  - FETCH, DECODE, EXEC with alu_code=001, WB with rf_we=1 and rf_dst_sel=0.
  - retired 0->1 after 4 cycles.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM:
  - mem_req stays high and stable throughout, mem_addr_sel=1 in MEM.
  - WB has rf_wdata_sel=1, rf_dst_sel=1.
  - Total 11 cycles.
- beq with zero=1, then beq with zero=0:
  - zero=1: pc_we=1, pc_src=01 in EXEC.
  - zero=0: no pc_we in EXEC.
  - Both retire in 3 cycles.
- R-type func=0010:
  - illegal=1, halted=1 one cycle after DECODE, no rf_we; retired unchanged.
  - A later mem_ready pulse has no effect.
- mem_ready never asserted with MEM_TIMEOUT=8:
  - bus_err=1 and HALT after 8 FETCH cycles.
  - Variant: ready on the 8th cycle proceeds normally.
- rst_n pulsed low mid-MEM of sw:
  - Outputs 0 immediately, with no mem_we completion.
  - IDLE then FETCH after deassert; retired=0, flags cleared.
